vga_sync: RTL



---
 rtl/vga_timing_pkg.sv | 37 +++
 rtl/vga_sync_if.sv | 23 ++
 rtl/vga_pixel_tick.sv | 43 ++++
 rtl/vga_sync.sv | 100 ++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared raster timing constants for the sync generator and the colour
//   stage: the 640x480 default porch/sync widths, the derived line/frame
//   totals, the sync window bounds and the visible extent (MAX_X/MAX_Y).
//   Also provides a small window-compare helper used by the sync decode.
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;
    localparam int DEF_CLK_DIV   = 2;

    localparam int DEF_H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam int DEF_H_SYNC_START = DEF_H_DISPLAY + DEF_H_FRONT;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
    localparam int DEF_V_SYNC_START = DEF_V_DISPLAY + DEF_V_FRONT;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

    // Visible extent as seen by the colour stage.
    localparam int MAX_X = DEF_H_DISPLAY;
    localparam int MAX_Y = DEF_V_DISPLAY;

    // True when v lies in the inclusive range [lo, hi].
    function automatic logic in_window(input logic [CNT_W-1:0] v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_if.sv
// vga_sync_if
//   Raster bundle from the sync generator (master) to the colour stage and
//   monitor connector (slave).
//     p_tick    : one-clk pulse per pixel period
//     pixel_x/y : current raster position
//     video_on  : inside the visible region
//     hsync     : horizontal sync, active-low
//     vsync     : vertical sync, active-low
//     frame_end : one-clk pulse on the tick that wraps the frame
interface vga_sync_if;
    import vga_timing_pkg::*;

    logic             p_tick;
    logic [CNT_W-1:0] pixel_x;
    logic [CNT_W-1:0] pixel_y;
    logic             video_on;
    logic             hsync;
    logic             vsync;
    logic             frame_end;

    modport master (output p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_end);
    modport slave  (input  p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_end);
endinterface

// File: rtl/vga_pixel_tick.sv
// vga_pixel_tick
//   Clock-enable divider: p_tick is a registered one-clk pulse every CLK_DIV
//   system clocks. After reset release the first pulse appears CLK_DIV clocks
//   later; with CLK_DIV=1 the pulse is constantly high from the first clock.
//   Ports: clk, rst (async, active-high), p_tick (out).
module vga_pixel_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic p_tick
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] div_next;
    logic             p_tick_reg;

    generate
        if (CLK_DIV < 1) begin : g_bad_div
            $error("vga_pixel_tick: CLK_DIV must be at least 1");
        end
    endgenerate

    always_comb begin
        div_next = (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
    end

    // The pulse is registered from the terminal divider count, so it lands
    // one clock after the divider reaches CLK_DIV-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg    <= '0;
            p_tick_reg <= 1'b0;
        end else begin
            div_reg    <= div_next;
            p_tick_reg <= (div_reg == DIV_LAST);
        end
    end

    assign p_tick = p_tick_reg;
endmodule

// File: rtl/vga_sync.sv
// vga_sync
//   Raster timing generator. Divides clk to the pixel rate, sweeps pixel_x
//   over 0..H_TOTAL-1 and pixel_y over 0..V_TOTAL-1 (blanking included) and
//   decodes video_on, hsync/vsync (active-low) and a frame_end pulse.
//   Ports: clk, rst (async, active-high), vga (vga_sync_if.master).
module vga_sync
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int CLK_DIV   = DEF_CLK_DIV
) (
    input logic        clk,
    input logic        rst,
    vga_sync_if.master vga
);
    localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    generate
        if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_total
            $error("vga_sync: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
        end
    endgenerate

    logic             p_tick;
    logic [CNT_W-1:0] x_reg, x_next;
    logic [CNT_W-1:0] y_reg, y_next;
    logic             hsync_reg, hsync_next;
    logic             vsync_reg, vsync_next;
    logic             frame_end_reg, frame_end_next;

    vga_pixel_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .p_tick (p_tick)
    );

    always_comb begin
        x_next         = x_reg;
        y_next         = y_reg;
        frame_end_next = 1'b0;
        if (p_tick) begin
            if (x_reg == H_LAST) begin
                x_next = '0;
                if (y_reg == V_LAST) begin
                    y_next         = '0;
                    frame_end_next = 1'b1;
                end else begin
                    y_next = y_reg + 1'b1;
                end
            end else begin
                x_next = x_reg + 1'b1;
            end
        end
        // Decoded from the next-state counters so the registered syncs line
        // up with the registered position they describe.
        hsync_next = !in_window(x_next, H_SYNC_START, H_SYNC_END);
        vsync_next = !in_window(y_next, V_SYNC_START, V_SYNC_END);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg         <= '0;
            y_reg         <= '0;
            hsync_reg     <= 1'b1;
            vsync_reg     <= 1'b1;
            frame_end_reg <= 1'b0;
        end else begin
            x_reg         <= x_next;
            y_reg         <= y_next;
            hsync_reg     <= hsync_next;
            vsync_reg     <= vsync_next;
            frame_end_reg <= frame_end_next;
        end
    end

    assign vga.p_tick    = p_tick;
    assign vga.pixel_x   = x_reg;
    assign vga.pixel_y   = y_reg;
    assign vga.video_on  = (int'(x_reg) < H_DISPLAY) && (int'(y_reg) < V_DISPLAY);
    assign vga.hsync     = hsync_reg;
    assign vga.vsync     = vsync_reg;
    assign vga.frame_end = frame_end_reg;
endmodule
